// File: rtl/alu32_responder.sv
// Request/response wrapper around a 32-bit ALU: requests are evaluated on accept and
// the result plus flags are queued in a small FIFO drained over a valid/ready channel.
module alu32_responder #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_A,
   input  logic [31:0]      req_B,
   input  logic [2:0]       req_control,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_out,
   output logic             rsp_overflow,
   output logic             rsp_zero,
   output logic             rsp_negative,
   output logic             rsp_illegal,
   output logic [CNT_W-1:0] op_count,
   output logic             sticky_overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

   typedef struct packed {
      logic [31:0] out;
      logic        ovf;
      logic        zero;
      logic        neg;
      logic        ill;
   } entry_t;

   typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} occ_state_t;

   function automatic entry_t alu_eval(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] ctl);
      entry_t     e;
      logic [31:0] r;
      e = '0;
      r = '0;
      case (ctl)
         3'd2: begin
            r     = a + b;
            e.ovf = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'd3: begin
            r     = a - b;
            e.ovf = (a[31] != b[31]) && (r[31] != a[31]);
         end
         3'd4:    r = a & b;
         3'd5:    r = a | b;
         3'd6:    r = ~(a | b);
         3'd7:    r = a ^ b;
         default: e.ill = 1'b1;
      endcase
      e.out  = r;
      e.zero = (r == 32'd0);
      e.neg  = r[31];
      return e;
   endfunction

   occ_state_t       state_q, state_d;
   logic [OCC_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] op_count_q;
   logic             sticky_q;
   entry_t           mem_q [DEPTH];
   entry_t           new_entry;
   entry_t           head;
   logic             push, pop;

   // Ready is forced low while reset is held so no request is taken during reset.
   assign req_ready = reset & (state_q != S_FULL);
   assign rsp_valid = (state_q != S_EMPTY);
   assign push      = req_valid & req_ready;
   assign pop       = rsp_valid & rsp_ready;
   assign new_entry = alu_eval(req_A, req_B, req_control);

   always_comb begin
      count_d = count_q;
      state_d = state_q;
      case ({push, pop})
         2'b10:   count_d = count_q + OCC_W'(1);
         2'b01:   count_d = count_q - OCC_W'(1);
         default: count_d = count_q;
      endcase
      if (count_d == '0)
         state_d = S_EMPTY;
      else if (count_d == DEPTH_C)
         state_d = S_FULL;
      else
         state_d = S_PARTIAL;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_EMPTY;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         op_count_q <= '0;
         sticky_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) begin
            wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
            op_count_q <= op_count_q + CNT_W'(1);
            sticky_q   <= sticky_q | new_entry.ovf;
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Storage is not reset; an empty FIFO masks whatever stale contents remain.
   always_ff @(posedge clock) begin
      if (push)
         mem_q[wr_ptr_q] <= new_entry;
   end

   assign head            = rsp_valid ? mem_q[rd_ptr_q] : '0;
   assign rsp_out         = head.out;
   assign rsp_overflow    = head.ovf;
   assign rsp_zero        = head.zero;
   assign rsp_negative    = head.neg;
   assign rsp_illegal     = head.ill;
   assign op_count        = op_count_q;
   assign sticky_overflow = sticky_q;

endmodule

// File: tb/tb_alu32_responder.sv
// Randomized bench for alu32_responder: a queue-based reference model is compared against
// the DUT on every falling clock edge, plus literal checks that pin the model.
module tb_alu32_responder;

   localparam int DEPTH = 2;
   localparam int CNT_W = 4;

   logic             clock;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_A;
   logic [31:0]      req_B;
   logic [2:0]       req_control;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_out;
   logic             rsp_overflow;
   logic             rsp_zero;
   logic             rsp_negative;
   logic             rsp_illegal;
   logic [CNT_W-1:0] op_count;
   logic             sticky_overflow;

   alu32_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_A(req_A), .req_B(req_B), .req_control(req_control),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
      .rsp_negative(rsp_negative), .rsp_illegal(rsp_illegal),
      .op_count(op_count), .sticky_overflow(sticky_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] out;
      bit          ovf;
      bit          zero;
      bit          neg;
      bit          ill;
   } mres_t;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   localparam longint MAXS = 64'sh7fffffff;
   localparam longint MINS = -64'sh80000000;

   // Arithmetic done in wide signed integers; overflow means the exact result leaves 32 bits.
   function automatic mres_t ref_op(input int ctl, input logic [31:0] a, input logic [31:0] b);
      mres_t  r;
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s  = 0;
      r.out = 32'd0; r.ovf = 1'b0; r.ill = 1'b0;
      case (ctl)
         2: begin s = sa + sb; r.out = s[31:0]; r.ovf = (s > MAXS) || (s < MINS); end
         3: begin s = sa - sb; r.out = s[31:0]; r.ovf = (s > MAXS) || (s < MINS); end
         4: r.out = a & b;
         5: r.out = a | b;
         6: r.out = ~(a | b);
         7: r.out = a ^ b;
         default: r.ill = 1'b1;
      endcase
      r.zero = (r.out == 32'd0);
      r.neg  = r.out[31];
      return r;
   endfunction

   function automatic logic [35:0] pack(input mres_t r);
      return {r.out, r.ovf, r.zero, r.neg, r.ill};
   endfunction

   mres_t model_q[$];
   int    model_cnt = 0;
   bit    model_sticky = 1'b0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         model_q.delete();
         model_cnt    = 0;
         model_sticky = 1'b0;
      end else begin
         bit    acc, pp;
         mres_t r;
         acc = req_valid && (model_q.size() < DEPTH);
         pp  = rsp_ready && (model_q.size() != 0);
         r   = ref_op(int'(req_control), req_A, req_B);
         if (pp) void'(model_q.pop_front());
         if (acc) begin
            model_q.push_back(r);
            model_cnt    = (model_cnt + 1) % (1 << CNT_W);
            model_sticky = model_sticky | r.ovf;
         end
      end
   end

   always @(negedge clock) begin
      mres_t h;
      h = '{32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      if (model_q.size() != 0) h = model_q[0];
      chk("req_ready", 64'(req_ready), 64'(reset && (model_q.size() < DEPTH)));
      chk("rsp_valid", 64'(rsp_valid), 64'(model_q.size() != 0));
      chk("rsp_data", 64'({rsp_out, rsp_overflow, rsp_zero, rsp_negative, rsp_illegal}),
          64'(pack(h)));
      chk("op_count", 64'(op_count), 64'(model_cnt));
      chk("sticky", 64'(sticky_overflow), 64'(model_sticky));
   end

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0: return 32'h7fffffff;
         1: return 32'h80000000;
         2: return 32'h00000000;
         3: return 32'hffffffff;
         4: return 32'(  $urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic drive(input bit v, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input bit rr);
      @(posedge clock);
      #1;
      req_valid   = v;
      req_control = c;
      req_A       = a;
      req_B       = b;
      rsp_ready   = rr;
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_control = 3'd0;
      req_A = 32'd0; req_B = 32'd0; rsp_ready = 1'b1;

      // Pin the reference model with hand-computed values.
      chk("pin_add",   64'(pack(ref_op(2, 32'd8, 32'd4))),          {28'd0, 32'd12, 4'b0000});
      chk("pin_sub",   64'(pack(ref_op(3, 32'd2, 32'd5))),          {28'd0, 32'hFFFFFFFD, 4'b0010});
      chk("pin_subz",  64'(pack(ref_op(3, 32'h7fffffff, 32'h7fffffff))), {28'd0, 32'd0, 4'b0100});
      chk("pin_addov", 64'(pack(ref_op(2, 32'h7fffffff, 32'h7fffffff))), {28'd0, 32'hFFFFFFFE, 4'b1010});
      chk("pin_addmn", 64'(pack(ref_op(2, 32'h80000000, 32'h80000000))), {28'd0, 32'd0, 4'b1100});
      chk("pin_subov", 64'(pack(ref_op(3, 32'h7fffffff, 32'h80000000))), {28'd0, 32'hFFFFFFFF, 4'b1010});
      chk("pin_nor",   64'(pack(ref_op(6, 32'h0000ffff, 32'h00ff0000))), {28'd0, 32'hFF000000, 4'b0010});
      chk("pin_ill",   64'(pack(ref_op(1, 32'd9, 32'd9))),          {28'd0, 32'd0, 4'b0101});

      repeat (3) @(posedge clock);
      #1 reset = 1'b1;

      // ADD 8+4: result visible one edge after accept.
      drive(1'b1, 3'd2, 32'd8, 32'd4, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      @(negedge clock);
      chk("lit_add_out", 64'(rsp_out), 64'd12);
      chk("lit_add_cnt", 64'(op_count), 64'd1);

      // Overflow corners, then illegal op.
      drive(1'b1, 3'd3, 32'd2, 32'd5, 1'b1);
      drive(1'b1, 3'd2, 32'h7fffffff, 32'h7fffffff, 1'b1);
      drive(1'b1, 3'd2, 32'h80000000, 32'h80000000, 1'b1);
      drive(1'b1, 3'd3, 32'h7fffffff, 32'h80000000, 1'b1);
      drive(1'b1, 3'd0, 32'h12345678, 32'd1, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      @(negedge clock);
      chk("lit_sticky", 64'(sticky_overflow), 64'd1);

      // Back-pressure: three requests with consumer stalled, then drain.
      drive(1'b1, 3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
      drive(1'b1, 3'd5, 32'h0000000F, 32'h000000F0, 1'b0);
      drive(1'b1, 3'd7, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0);
      drive(1'b1, 3'd7, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0);
      @(negedge clock);
      chk("lit_full_rdy", 64'(req_ready), 64'd0);
      drive(1'b1, 3'd7, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b1);
      drive(1'b1, 3'd6, 32'd0, 32'd0, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      repeat (3) drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

      // Randomized traffic including op_count wrap.
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick_operand(),
               pick_operand(), $urandom_range(0, 2) != 0);

      // Reset with two queued results must discard them immediately.
      drive(1'b1, 3'd2, 32'h7fffffff, 32'd1, 1'b0);
      drive(1'b1, 3'd2, 32'd1, 32'd1, 1'b0);
      drive(1'b1, 3'd2, 32'd1, 32'd1, 1'b0);
      @(posedge clock);
      #3 reset = 1'b0;
      #1;
      chk("lit_rst_valid", 64'(rsp_valid), 64'd0);
      chk("lit_rst_cnt", 64'(op_count), 64'd0);
      chk("lit_rst_sticky", 64'(sticky_overflow), 64'd0);
      chk("lit_rst_ready", 64'(req_ready), 64'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      #1;
      chk("lit_rel_ready", 64'(req_ready), 64'd1);

      for (int i = 0; i < 200; i++)
         drive($urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)), pick_operand(),
               pick_operand(), $urandom_range(0, 3) != 0);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      repeat (4) @(posedge clock);
      @(negedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
